// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: op encodings, FSM states,
// default window/timeout parameters and small op classification helpers.
package mem_access_pkg;

    localparam logic [31:0] ADDR_LIMIT_DEFAULT     = 32'h0000_3000;
    localparam int          TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Codes 9..15 are unused and behave exactly like NONE.
    function automatic mem_op_e decode_op(input logic [3:0] raw);
        if (raw > 4'd8) begin
            return OP_NONE;
        end
        return mem_op_e'(raw);
    endfunction

    function automatic logic op_is_load(input mem_op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic op_is_word(input mem_op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_is_half(input mem_op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic op_is_byte(input mem_op_e op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the byte/half lane addressed by the
// low address bits out of the read word and sign- or zero-extends it.
module mem_load_align
    import mem_access_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[byte_off];
    assign half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane according to the load flavour.
    always_comb begin
        data = rdata;
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a simple req/gnt/rvalid memory.
// Checks alignment and window, drives lane enables and replicated write
// data, aligns load results, and times out stuck requests with BusErr.
// Optional: define MEM_ACCESS_TRACE_EN to print one line per granted store.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT     = ADDR_LIMIT_DEFAULT,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Valid,
    input  logic [3:0]  MemOp,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    input  logic [31:0] PC,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        LoadValid,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    input  logic        MemGnt,
    input  logic        MemRValid,
    input  logic [31:0] MemRData
);

    // The counter is cleared on entering a wait state, so it reads k-1 in
    // the k-th cycle; expiring at TIMEOUT_CYCLES-1 gives exactly
    // TIMEOUT_CYCLES wait cycles before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_e  state_reg, state_next;
    mem_op_e     op_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  byte_en_reg;
    logic        we_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] load_data_reg;
    logic        addr_err_reg;
    logic        bus_err_reg;

    mem_op_e     in_op;
    logic        in_aligned;
    logic        in_legal;
    logic        start_access;
    logic        illegal_access;
    logic        wait_expired;
    logic [3:0]  in_byte_en;
    logic [31:0] in_wdata;
    logic [31:0] aligned_data;
    logic        stall_c;
    logic        mem_req_c;

    assign in_op          = decode_op(MemOp);
    assign in_legal       = in_aligned && (Addr < ADDR_LIMIT);
    assign start_access   = (state_reg == ST_IDLE) && Valid && (in_op != OP_NONE) && in_legal;
    assign illegal_access = (state_reg == ST_IDLE) && Valid && (in_op != OP_NONE) && !in_legal;
    assign wait_expired   = (cnt_reg == TIMEOUT_LAST);

    // Alignment rule and lane placement for the access being presented.
    always_comb begin
        in_aligned = 1'b1;
        in_byte_en = 4'b1111;
        in_wdata   = StoreData;
        if (op_is_word(in_op)) begin
            in_aligned = (Addr[1:0] == 2'b00);
        end else if (op_is_half(in_op)) begin
            in_aligned = (Addr[0] == 1'b0);
            in_byte_en = 4'b0011 << {Addr[1], 1'b0};
            in_wdata   = {2{StoreData[15:0]}};
        end else if (op_is_byte(in_op)) begin
            in_byte_en = 4'b0001 << Addr[1:0];
            in_wdata   = {4{StoreData[7:0]}};
        end
    end

    mem_load_align u_align (
        .op       (op_reg),
        .byte_off (addr_reg[1:0]),
        .rdata    (MemRData),
        .data     (aligned_data)
    );

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the stall and request strobes.
    always_comb begin
        state_next = state_reg;
        stall_c    = 1'b0;
        mem_req_c  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_access) begin
                    state_next = ST_REQ;
                    stall_c    = 1'b1;
                end
            end
            ST_REQ: begin
                stall_c   = 1'b1;
                mem_req_c = 1'b1;
                if (MemGnt) begin
                    state_next = we_reg ? ST_DONE : ST_RESP;
                end else if (wait_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_RESP: begin
                stall_c = 1'b1;
                if (MemRValid || wait_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Access latch, wait counter, load result and error pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_reg        <= OP_NONE;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            byte_en_reg   <= 4'h0;
            we_reg        <= 1'b0;
            cnt_reg       <= 8'h0;
            load_data_reg <= 32'h0;
            addr_err_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            addr_err_reg <= illegal_access;
            bus_err_reg  <= 1'b0;
            if (start_access) begin
                op_reg      <= in_op;
                addr_reg    <= Addr;
                wdata_reg   <= in_wdata;
                byte_en_reg <= in_byte_en;
                we_reg      <= op_is_store(in_op);
            end
            if ((state_next != state_reg) &&
                ((state_next == ST_REQ) || (state_next == ST_RESP))) begin
                cnt_reg <= 8'h0;
            end else if ((state_reg == ST_REQ) || (state_reg == ST_RESP)) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
            if ((state_reg == ST_RESP) && MemRValid) begin
                load_data_reg <= aligned_data;
            end else if (((state_reg == ST_REQ) && !MemGnt && wait_expired) ||
                         ((state_reg == ST_RESP) && !MemRValid && wait_expired)) begin
                bus_err_reg   <= 1'b1;
                load_data_reg <= 32'h0;
            end
        end
    end

`ifdef MEM_ACCESS_TRACE_EN
    logic [31:0] pc_reg;

    // Remember the PC of the access for the store trace.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_reg <= 32'h0;
        end else if (start_access) begin
            pc_reg <= PC;
        end
    end

    // One trace line per store, on its grant cycle.
    always_ff @(posedge Clk) begin
        if (!Reset && (state_reg == ST_REQ) && MemGnt && we_reg) begin
            $display("@%08h: *%08h <= %08h", pc_reg, addr_reg, wdata_reg);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC;
`endif

    assign Stall     = stall_c;
    assign MemReq    = mem_req_c;
    assign MemWE     = we_reg;
    assign MemAddr   = {addr_reg[31:2], 2'b00};
    assign MemByteEn = byte_en_reg;
    assign MemWData  = wdata_reg;
    assign LoadData  = load_data_reg;
    assign AddrErr   = addr_err_reg;
    assign BusErr    = bus_err_reg;
    // A timed-out load reports BusErr instead of a valid result.
    assign LoadValid = (state_reg == ST_DONE) && op_is_load(op_reg) && !bus_err_reg;

endmodule
